key_schedule_fsm: RTL and testbench

//  Sequential AES-128 key expansion engine: produces round keys 0..10 one at a time, on request.
//  - Feeds the synchronous subWord stage: drives rotWord(w3) on sw_a.
//  - Consumes sw_y one S-box latency later and forms the next round key from it.
//  - Sits between the key input register and the round datapath of the AES core.

---
 rtl/key_schedule_fsm.sv | 79 +++++++
 tb/tb_key_schedule_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_fsm.sv
// key_schedule_fsm: sequential AES-128 key expansion, one round key per request via an external subWord stage
module key_schedule_fsm #(
  parameter int NR       = 10,
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         next,
  output logic [31:0]  sw_a,
  input  logic [31:0]  sw_y,
  output logic [127:0] round_key,
  output logic [3:0]   round,
  output logic         key_valid,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, HOLD, SUB, EXP} state_t;
  localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  state_t       r_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic         r_valid;
  logic         r_done;
  logic [1:0]   r_cnt;
  logic [3:0]   w_round_nx;
  logic [31:0]  w_t, w_w0, w_w1, w_w2, w_w3;
  assign sw_a       = {r_key[23:0], r_key[31:24]};
  assign w_round_nx = r_round + 4'd1;
  assign w_t        = sw_y ^ {RCON[w_round_nx], 24'h0};
  assign w_w0       = r_key[127:96] ^ w_t;
  assign w_w1       = r_key[95:64] ^ w_w0;
  assign w_w2       = r_key[63:32] ^ w_w1;
  assign w_w3       = r_key[31:0] ^ w_w2;
  assign round_key  = r_key;
  assign round      = r_round;
  assign key_valid  = r_valid;
  assign done       = r_done;
  // start overrides every state, so an in-flight expansion is simply discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else if (start) begin
      r_state <= HOLD;
      r_key   <= key;
      r_round <= '0;
      r_valid <= 1'b1;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: r_valid <= 1'b0;
        HOLD: if (next && r_round < 4'(NR)) begin
          r_state <= SUB;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= '0;
        end
        SUB: begin
          r_state <= (r_cnt == 2'(SBOX_LAT - 1)) ? EXP : SUB;
          r_cnt   <= r_cnt + 2'd1;
        end
        EXP: begin
          r_state <= HOLD;
          r_key   <= {w_w0, w_w1, w_w2, w_w3};
          r_round <= w_round_nx;
          r_valid <= 1'b1;
          r_done  <= (w_round_nx == 4'(NR));
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_schedule_fsm.sv
// tb_key_schedule_fsm: directed checks of the key schedule against FIPS-197 round keys, S-box latency 1 and 3
module tb_key_schedule_fsm;
  logic         clk, reset;
  logic [127:0] key;
  logic         st [2];
  logic         nx [2];
  logic [31:0]  swa [2];
  logic [31:0]  swy [2];
  logic [127:0] rk [2];
  logic [3:0]   rd [2];
  logic         kv [2];
  logic         dn [2];
  logic [31:0]  p1, p2;
  int           tests = 0;
  int           fails = 0;
  localparam logic [127:0] K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] exp_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sb(input logic [7:0] b);
    return sbox_flat[2047 - 8 * int'(b) -: 8];
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction
  key_schedule_fsm #(.NR(10), .SBOX_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(st[0]), .key(key), .next(nx[0]),
    .sw_a(swa[0]), .sw_y(swy[0]), .round_key(rk[0]), .round(rd[0]),
    .key_valid(kv[0]), .done(dn[0]));
  key_schedule_fsm #(.NR(10), .SBOX_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(st[1]), .key(key), .next(nx[1]),
    .sw_a(swa[1]), .sw_y(swy[1]), .round_key(rk[1]), .round(rd[1]),
    .key_valid(kv[1]), .done(dn[1]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // S-box stubs: one register for latency 1, a three-register pipe for latency 3
  always @(posedge clk) begin
    swy[0] <= subw(swa[0]);
    p1     <= subw(swa[1]);
    p2     <= p1;
    swy[1] <= p2;
  end
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    nx[0] = 1'b1;
    nx[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({kv[d], dn[d], rd[d], rk[d], swa[d]} !== {1'b0, 1'b0, 4'd0, 128'h0, 32'h0}) begin
        fails++;
        $display("FAIL reset d%0d: got kv=%b dn=%b rd=%0d rk=%h swa=%h want all zero", d, kv[d], dn[d], rd[d], rk[d], swa[d]);
      end
    end
    repeat (3) @(negedge clk);
    nx[0] = 1'b0;
    nx[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({kv[d], rd[d], rk[d]} !== {1'b0, 4'd0, 128'h0}) begin
        fails++;
        $display("FAIL next_in_idle d%0d: got kv=%b rd=%0d rk=%h want 0/0/0", d, kv[d], rd[d], rk[d]);
      end
    end
  endtask
  task automatic test_load(input int d);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    tests++;
    if ({kv[d], dn[d], rd[d], rk[d], swa[d]} !== {1'b1, 1'b0, 4'd0, K, 32'hcf4f3c09}) begin
      fails++;
      $display("FAIL load d%0d: got kv=%b dn=%b rd=%0d rk=%h swa=%h want 1/0/0/%h/cf4f3c09", d, kv[d], dn[d], rd[d], rk[d], swa[d], K);
    end
  endtask
  task automatic test_step(input int d, input int r);
    int lat = d ? 3 : 1;
    nx[d] = 1'b1;
    for (int i = 1; i <= lat + 1; i++) begin
      @(negedge clk);
      nx[d] = 1'b0;
      tests++;
      if ({kv[d], dn[d], rd[d], rk[d]} !== {1'b0, 1'b0, 4'(r - 1), exp_rk[r - 1]}) begin
        fails++;
        $display("FAIL busy d%0d r%0d c%0d: got kv=%b dn=%b rd=%0d rk=%h want 0/0/%0d/%h", d, r, i, kv[d], dn[d], rd[d], rk[d], r - 1, exp_rk[r - 1]);
      end
    end
    @(negedge clk);
    tests++;
    if ({kv[d], dn[d], rd[d], rk[d]} !== {1'b1, r == 10, 4'(r), exp_rk[r]}) begin
      fails++;
      $display("FAIL round d%0d r%0d: got kv=%b dn=%b rd=%0d rk=%h want 1/%b/%0d/%h", d, r, kv[d], dn[d], rd[d], rk[d], r == 10, r, exp_rk[r]);
    end
  endtask
  task automatic test_run_to_end(input int d);
    int lat = d ? 3 : 1;
    for (int r = 3; r <= 10; r++) test_step(d, r);
    nx[d] = 1'b1;
    for (int i = 0; i < lat + 3; i++) begin
      @(negedge clk);
      nx[d] = 1'b0;
      tests++;
      if ({kv[d], dn[d], rd[d], rk[d]} !== {1'b1, 1'b1, 4'd10, exp_rk[10]}) begin
        fails++;
        $display("FAIL next_at_nr d%0d c%0d: got kv=%b dn=%b rd=%0d rk=%h want 1/1/10/%h", d, i, kv[d], dn[d], rd[d], rk[d], exp_rk[10]);
      end
    end
  endtask
  task automatic test_abort(input int d);
    int lat = d ? 3 : 1;
    int i;
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    nx[d] = 1'b1;
    for (i = 0; i < 80 && !(kv[d] === 1'b1 && rd[d] === 4'd3); i++) @(negedge clk);
    tests++;
    if (i >= 80) begin
      fails++;
      nx[d] = 1'b0;
      $display("FAIL abort_reach d%0d: round 3 never held within 80 cycles, got rd=%0d want 3", d, rd[d]);
      return;
    end
    repeat (lat + 1) @(negedge clk);
    tests++;
    if ({kv[d], rd[d], rk[d]} !== {1'b0, 4'd3, exp_rk[3]}) begin
      fails++;
      $display("FAIL abort_exp d%0d: got kv=%b rd=%0d rk=%h want 0/3/%h", d, kv[d], rd[d], rk[d], exp_rk[3]);
    end
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    tests++;
    if ({kv[d], dn[d], rd[d], rk[d]} !== {1'b1, 1'b0, 4'd0, K}) begin
      fails++;
      $display("FAIL abort_reload d%0d: got kv=%b dn=%b rd=%0d rk=%h want 1/0/0/%h", d, kv[d], dn[d], rd[d], rk[d], K);
    end
    for (int r = 1; r <= 2; r++) begin
      repeat (lat + 2) @(negedge clk);
      tests++;
      if ({kv[d], rd[d], rk[d]} !== {1'b1, 4'(r), exp_rk[r]}) begin
        fails++;
        $display("FAIL abort_follow d%0d r%0d: got kv=%b rd=%0d rk=%h want 1/%0d/%h", d, r, kv[d], rd[d], rk[d], r, exp_rk[r]);
      end
    end
    nx[d] = 1'b0;
  endtask
  task automatic test_reset_mid();
    nx[0] = 1'b1;
    @(negedge clk);
    nx[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({kv[d], dn[d], rd[d], rk[d], swa[d]} !== {1'b0, 1'b0, 4'd0, 128'h0, 32'h0}) begin
        fails++;
        $display("FAIL reset_mid d%0d: got kv=%b dn=%b rd=%0d rk=%h swa=%h want all zero", d, kv[d], dn[d], rd[d], rk[d], swa[d]);
      end
    end
  endtask
  initial begin
    reset = 1'b1;
    key   = K;
    st[0] = 1'b0;
    st[1] = 1'b0;
    nx[0] = 1'b0;
    nx[1] = 1'b0;
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_load(d);
      test_step(d, 1);
      test_step(d, 2);
      test_run_to_end(d);
      test_abort(d);
    end
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
